mo_pixel_shifter: RTL and testbench
===================================

Name: mo_pixel_shifter

Overview:
Parametrised motion-object pixel serialiser: accepts bit-planar picture words from the MO picture ROMs and emits one BPP-bit pixel per pixel-clock enable. It generalises the fixed 3-plane/4-pixel shifter in four ways: plane count and word width are parameters, flip is selectable per word, words arrive through a valid/ready handshake into a one-word buffer, and underrun is reported. It sits between the MO picture ROM fetch logic and the MO line buffer / colour mux.

Parameters:
BPP, 3, bits per pixel (number of bitplanes)
PPW, 4, pixels per loaded word (bits per plane)
TRANSP, all-ones of BPP, pixel value output when not matched, idle or underrun

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
pix_ce  in  1  pixel-clock enable; one pixel is produced per clk with pix_ce=1
flush  in  1  synchronous clear of buffer and shifter (start of line)
load_valid  in  1  load_data/load_match/load_flip are valid
load_ready  out  1  block can accept a word this clk
load_data  in  BPP*PPW  planes {plane BPP-1 .. plane 0}, each PPW bits
load_match  in  1  0 = word replaced by TRANSP on every pixel
load_flip  in  1  0 = emit pixel PPW-1 first; 1 = emit pixel 0 first
pix_out  out  BPP  current pixel, registered
pix_valid  out  1  pix_out came from a loaded word (vs idle/underrun fill)
underrun  out  1  one-clk pulse: pix_ce with no pixel available while armed

Behaviour:
- Reset (async, reset_n=0): buffer empty, shifter count=0, armed=0, pix_out=TRANSP, pix_valid=0, underrun=0; load_ready=1 once reset_n=1.
- Pixel i of a word = {plane[BPP-1][i], ..., plane[0][i]}. Match gating happens at buffer write: load_match=0 stores all planes as ones.
- Buffer: one entry. Handshake: transfer occurs when load_valid & load_ready. load_ready = ~flush & (~buf_full | buf_pop), where buf_pop is the clk the buffer moves into the shifter (combinational, no bubble at steady state).
- Shifter: holds PPW pixels, count 0..PPW, flip bit latched with the word.
- On a clk with pix_ce=1:
  count>0: pix_out <= head pixel (order per latched flip), count--, pix_valid<=1.
  count==0 and buf_full: load shifter from buffer AND emit its first pixel in the same clk, count<=PPW-1, buffer empties (unless refilled same clk). Back-to-back words therefore stream with no gap.
  count==0 and buffer empty: pix_out<=TRANSP, pix_valid<=0; underrun<=1 if armed.
- pix_ce=0: pix_out, pix_valid and count hold; underrun<=0.
- armed sets on first accepted word after reset/flush; it clears on flush or reset.
- Latency: word accepted into an idle block at clk N → first pixel on pix_out after the first pix_ce clk > N.
- flush=1: buffer empty, count=0, armed=0, pix_out<=TRANSP, pix_valid<=0 next clk; concurrent load ignored (load_ready=0); flush overrides pix_ce.
- Reset mid-word discards all state; no partial pixels are emitted afterwards.

Decomposition:
- Package mo_pkg: TRANSP default function, the plane-to-pixel index helper, and the default BPP/PPW constants shared with the ROM fetch block.
- One sub-module mo_word_buffer: the one-entry holding register with valid/ready, match gating and flip capture. Serialisation and counters stay in the top.

Test Plan (BPP=3, PPW=4):
- Reset: reset_n=0 mid-stream → pix_out=3'b111, pix_valid=0, load_ready=1 after release; no underrun until first load.
- Normal order: load 12'hAC6, match=1, flip=0, pix_ce every clk → pix_out 6,3,5,0 with pix_valid=1, then 7 with underrun pulse.
- Flip: same word, flip=1 → 0,5,3,6.
- Unmatched: 12'hAC6, match=0 → four pixels 7 with pix_valid=1.
- Streaming: two words presented back-to-back, pix_ce every 4th clk → 8 consecutive valid pixels, no TRANSP gap; load_ready drops while buffer full and shifter busy.
- Flush: flush during pixel 2 with load_valid=1 → next clk pix_out=7, pix_valid=0; the word is not accepted and the next pix_ce gives no underrun.

Source files
------------

// File: rtl/mo_pkg.sv
// Shared constants and helpers for the motion-object picture path.
// The ROM fetch block and the pixel shifter both import this package.
package mo_pkg;

    localparam int MO_BPP = 3;
    localparam int MO_PPW = 4;

    // All-ones pixel of the given depth, used as the transparent colour.
    function automatic logic [31:0] transp_default(input int bpp);
        return (32'd1 << bpp) - 32'd1;
    endfunction

    // Bit position of pixel 'pixel' of plane 'plane' inside a packed picture word.
    function automatic int plane_bit(input int plane, input int pixel, input int ppw);
        return plane * ppw + pixel;
    endfunction

endpackage

// File: rtl/mo_word_buffer.sv
// One-entry holding register between the picture ROM fetch and the shifter.
// Unmatched words are stored as all-ones so they come out transparent.
module mo_word_buffer
    import mo_pkg::*;
#(
    parameter int BPP = MO_BPP,
    parameter int PPW = MO_PPW
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 flush,
    input  logic                 load_valid,
    input  logic [BPP*PPW-1:0]   load_data,
    input  logic                 load_match,
    input  logic                 load_flip,
    input  logic                 buf_pop,
    output logic                 load_ready,
    output logic                 buf_full,
    output logic [BPP*PPW-1:0]   buf_data,
    output logic                 buf_flip
);

    // A word may enter when the entry is free or is leaving this same clock.
    assign load_ready = ~flush & (~buf_full | buf_pop);

    // Entry register: flush empties it, a transfer fills it, a pop frees it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            buf_full <= 1'b0;
            buf_data <= '0;
            buf_flip <= 1'b0;
        end else if (flush) begin
            buf_full <= 1'b0;
        end else if (load_valid && load_ready) begin
            buf_full <= 1'b1;
            buf_data <= load_match ? load_data : '1;
            buf_flip <= load_flip;
        end else if (buf_pop) begin
            buf_full <= 1'b0;
        end
    end

endmodule

// File: rtl/mo_pixel_shifter.sv
// Motion-object pixel serialiser: turns bit-planar picture words into one
// pixel per pixel-clock enable, streaming back-to-back words without gaps.
module mo_pixel_shifter
    import mo_pkg::*;
#(
    parameter int             BPP    = MO_BPP,
    parameter int             PPW    = MO_PPW,
    parameter logic [BPP-1:0] TRANSP = BPP'(transp_default(BPP))
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 pix_ce,
    input  logic                 flush,
    input  logic                 load_valid,
    output logic                 load_ready,
    input  logic [BPP*PPW-1:0]   load_data,
    input  logic                 load_match,
    input  logic                 load_flip,
    output logic [BPP-1:0]       pix_out,
    output logic                 pix_valid,
    output logic                 underrun
);

    localparam int CW = $clog2(PPW + 1);
    localparam int WW = BPP * PPW;

    logic [CW-1:0]  count;
    logic [WW-1:0]  shift_word;
    logic           shift_flip;
    logic           armed;
    logic           buf_full;
    logic           buf_flip;
    logic [WW-1:0]  buf_data;
    logic           buf_pop;
    logic           accept;
    int             head_idx;
    logic [BPP-1:0] head_pix;
    logic [BPP-1:0] first_pix;

    // Gather one bit from every plane to form pixel 'idx' of a word.
    function automatic logic [BPP-1:0] pick_pixel(input logic [WW-1:0] w, input int idx);
        logic [BPP-1:0] p;
        logic [WW-1:0]  sh;
        p = '0;
        for (int b = 0; b < BPP; b++) begin
            sh   = w >> plane_bit(b, idx, PPW);
            p[b] = sh[0];
        end
        return p;
    endfunction

    mo_word_buffer #(
        .BPP (BPP),
        .PPW (PPW)
    ) u_buffer (
        .clk        (clk),
        .reset_n    (reset_n),
        .flush      (flush),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_match (load_match),
        .load_flip  (load_flip),
        .buf_pop    (buf_pop),
        .load_ready (load_ready),
        .buf_full   (buf_full),
        .buf_data   (buf_data),
        .buf_flip   (buf_flip)
    );

    assign accept  = load_valid & load_ready;
    assign buf_pop = pix_ce & ~flush & (count == '0) & buf_full;

    // Select the next pixel from the shifter and the first pixel of the buffered word.
    always_comb begin
        head_idx = 0;
        if (count != '0) begin
            head_idx = shift_flip ? (PPW - int'(count)) : (int'(count) - 1);
        end
        head_pix  = pick_pixel(shift_word, head_idx);
        first_pix = pick_pixel(buf_data, buf_flip ? 0 : PPW - 1);
    end

    // Underrun reporting is only armed once a word has arrived since reset or flush.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            armed <= 1'b0;
        end else if (flush) begin
            armed <= 1'b0;
        end else if (accept) begin
            armed <= 1'b1;
        end
    end

    // Shift out one pixel per enable, reloading from the buffer with no bubble.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count      <= '0;
            shift_word <= '0;
            shift_flip <= 1'b0;
            pix_out    <= TRANSP;
            pix_valid  <= 1'b0;
            underrun   <= 1'b0;
        end else if (flush) begin
            count      <= '0;
            pix_out    <= TRANSP;
            pix_valid  <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            underrun <= 1'b0;
            if (pix_ce) begin
                if (count != '0) begin
                    pix_out   <= head_pix;
                    pix_valid <= 1'b1;
                    count     <= count - CW'(1);
                end else if (buf_full) begin
                    shift_word <= buf_data;
                    shift_flip <= buf_flip;
                    pix_out    <= first_pix;
                    pix_valid  <= 1'b1;
                    count      <= CW'(PPW - 1);
                end else begin
                    pix_out   <= TRANSP;
                    pix_valid <= 1'b0;
                    underrun  <= armed;
                end
            end
        end
    end

endmodule

// File: tb/tb_mo_pixel_shifter.sv
// Self-checking bench for mo_pixel_shifter with BPP=3, PPW=4.
module tb_mo_pixel_shifter;

    localparam int BPP = 3;
    localparam int PPW = 4;

    typedef struct {
        logic [11:0] data;
        logic        match;
        logic        flip;
        logic [11:0] exp_pix;
    } vec_t;

    logic            clk;
    logic            reset_n;
    logic            pix_ce;
    logic            flush;
    logic            load_valid;
    logic            load_ready;
    logic [11:0]     load_data;
    logic            load_match;
    logic            load_flip;
    logic [BPP-1:0]  pix_out;
    logic            pix_valid;
    logic            underrun;

    int              checks;
    int              errors;
    logic [2:0]      exp_q[$];
    logic            ce_at_edge;
    vec_t            vecs[6];

    mo_pixel_shifter #(
        .BPP (BPP),
        .PPW (PPW)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .pix_ce     (pix_ce),
        .flush      (flush),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_data  (load_data),
        .load_match (load_match),
        .load_flip  (load_flip),
        .pix_out    (pix_out),
        .pix_valid  (pix_valid),
        .underrun   (underrun)
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Remember whether the last edge was a pixel-producing enable.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) ce_at_edge <= 1'b0;
        else          ce_at_edge <= pix_ce & ~flush;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [11:0] d, input logic m,
                                 input logic f, input logic ce, input logic fl);
        load_valid = v;
        load_data  = d;
        load_match = m;
        load_flip  = f;
        pix_ce     = ce;
        flush      = fl;
    endtask

    task automatic pushExp(input logic [11:0] e);
        for (int k = 0; k < PPW; k++) exp_q.push_back(e[11-3*k -: 3]);
    endtask

    task automatic flushCycle();
        applyStimulus(1'b0, 12'h000, 1'b0, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        checkOutput("flush_valid", {31'd0, pix_valid}, 32'd0);
        applyStimulus(1'b0, 12'h000, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Scoreboard: every valid pixel produced by an enable must match the queue head.
    always @(negedge clk) begin
        if (ce_at_edge && pix_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL sb_unexpected actual=%0h required=none", pix_out);
            end else begin
                logic [2:0] e;
                e = exp_q.pop_front();
                checkOutput("sb_pixel", {29'd0, pix_out}, {29'd0, e});
            end
        end
    end

    initial begin
        checks = 0;
        errors = 0;
        vecs[0] = '{12'hAC6, 1'b1, 1'b0, {3'd6, 3'd3, 3'd5, 3'd0}};
        vecs[1] = '{12'hAC6, 1'b1, 1'b1, {3'd0, 3'd5, 3'd3, 3'd6}};
        vecs[2] = '{12'hAC6, 1'b0, 1'b0, {3'd7, 3'd7, 3'd7, 3'd7}};
        vecs[3] = '{12'h123, 1'b1, 1'b0, {3'd0, 3'd0, 3'd3, 3'd5}};
        vecs[4] = '{12'h123, 1'b1, 1'b1, {3'd5, 3'd3, 3'd0, 3'd0}};
        vecs[5] = '{12'h9E4, 1'b1, 1'b1, {3'd4, 3'd2, 3'd3, 3'd6}};

        reset_n = 1'b0;
        applyStimulus(1'b0, 12'h000, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        checkOutput("rst_pix_out", {29'd0, pix_out}, 32'd7);
        checkOutput("rst_pix_valid", {31'd0, pix_valid}, 32'd0);
        checkOutput("rst_underrun", {31'd0, underrun}, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        checkOutput("rst_load_ready", {31'd0, load_ready}, 32'd1);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b0, 12'h000, 1'b0, 1'b0, 1'b1, 1'b0);
            @(negedge clk);
            checkOutput("idle_no_underrun", {31'd0, underrun}, 32'd0);
        end

        $display("[TB] table vectors");
        for (int i = 0; i < 6; i++) begin
            flushCycle();
            applyStimulus(1'b1, vecs[i].data, vecs[i].match, vecs[i].flip, 1'b1, 1'b0);
            #1;
            checkOutput("tbl_ready", {31'd0, load_ready}, 32'd1);
            pushExp(vecs[i].exp_pix);
            @(negedge clk);
            checkOutput("tbl_no_underrun", {31'd0, underrun}, 32'd0);
            applyStimulus(1'b0, 12'h000, 1'b0, 1'b0, 1'b1, 1'b0);
            repeat (4) @(negedge clk);
            @(negedge clk);
            checkOutput("tbl_end_pix", {29'd0, pix_out}, 32'd7);
            checkOutput("tbl_end_valid", {31'd0, pix_valid}, 32'd0);
            checkOutput("tbl_underrun", {31'd0, underrun}, 32'd1);
            checkOutput("tbl_sb_empty", exp_q.size(), 32'd0);
            applyStimulus(1'b0, 12'h000, 1'b0, 1'b0, 1'b0, 1'b0);
            @(negedge clk);
            checkOutput("tbl_underrun_clear", {31'd0, underrun}, 32'd0);
        end

        $display("[TB] streaming");
        flushCycle();
        for (int k = 0; k <= 36; k++) begin
            if (k == 0)
                applyStimulus(1'b1, 12'hAC6, 1'b1, 1'b0, 1'b1, 1'b0);
            else if (k <= 4)
                applyStimulus(1'b1, 12'h9E4, 1'b1, 1'b1, (k % 4) == 0, 1'b0);
            else
                applyStimulus(1'b0, 12'h000, 1'b0, 1'b0, (k % 4) == 0, 1'b0);
            #1;
            if (k == 1) checkOutput("stream_ready_full", {31'd0, load_ready}, 32'd0);
            if (k == 4) checkOutput("stream_ready_pop", {31'd0, load_ready}, 32'd1);
            if (k == 5) checkOutput("stream_ready_busy", {31'd0, load_ready}, 32'd0);
            if (k == 0) pushExp({3'd6, 3'd3, 3'd5, 3'd0});
            if (k == 4) pushExp({3'd4, 3'd2, 3'd3, 3'd6});
            @(negedge clk);
            if (k == 0) checkOutput("stream_no_underrun", {31'd0, underrun}, 32'd0);
            if (k >= 4 && k <= 32 && (k % 4) == 0)
                checkOutput("stream_valid", {31'd0, pix_valid}, 32'd1);
            if (k == 5) begin
                checkOutput("stream_hold_pix", {29'd0, pix_out}, 32'd6);
                checkOutput("stream_hold_valid", {31'd0, pix_valid}, 32'd1);
            end
            if (k == 36) checkOutput("stream_underrun", {31'd0, underrun}, 32'd1);
        end
        checkOutput("stream_sb_empty", exp_q.size(), 32'd0);

        $display("[TB] flush mid-word");
        flushCycle();
        applyStimulus(1'b1, 12'hAC6, 1'b1, 1'b0, 1'b1, 1'b0);
        pushExp({3'd6, 3'd3, 3'd5, 3'd0});
        @(negedge clk);
        applyStimulus(1'b0, 12'h000, 1'b0, 1'b0, 1'b1, 1'b0);
        repeat (2) @(negedge clk);
        applyStimulus(1'b1, 12'h123, 1'b1, 1'b0, 1'b1, 1'b1);
        #1;
        checkOutput("flush_ready", {31'd0, load_ready}, 32'd0);
        @(negedge clk);
        checkOutput("flush_pix", {29'd0, pix_out}, 32'd7);
        checkOutput("flush_pix_valid", {31'd0, pix_valid}, 32'd0);
        exp_q.delete();
        for (int k = 0; k < 2; k++) begin
            applyStimulus(1'b0, 12'h000, 1'b0, 1'b0, 1'b1, 1'b0);
            @(negedge clk);
            checkOutput("flush_no_underrun", {31'd0, underrun}, 32'd0);
            checkOutput("flush_not_accepted", {31'd0, pix_valid}, 32'd0);
        end

        $display("[TB] reset mid-word");
        flushCycle();
        applyStimulus(1'b1, 12'h9E4, 1'b1, 1'b0, 1'b1, 1'b0);
        pushExp({3'd6, 3'd3, 3'd2, 3'd4});
        @(negedge clk);
        applyStimulus(1'b0, 12'h000, 1'b0, 1'b0, 1'b1, 1'b0);
        repeat (2) @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("midrst_pix", {29'd0, pix_out}, 32'd7);
        checkOutput("midrst_valid", {31'd0, pix_valid}, 32'd0);
        exp_q.delete();
        @(negedge clk);
        reset_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checkOutput("midrst_no_pixel", {31'd0, pix_valid}, 32'd0);
            checkOutput("midrst_no_underrun", {31'd0, underrun}, 32'd0);
        end
        checkOutput("midrst_ready", {31'd0, load_ready}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
